// File: rtl/odd_parity_serial_tx_pkg.sv
// Shared definitions for the odd-parity serial transmitter: state codes,
// frame geometry and the parity function.
`timescale 1ns/1ps
package odd_parity_pkg;

  localparam int DATA_BITS  = 3;
  localparam int FRAME_BITS = 6;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  // High when the word has an even number of ones, so word+parity is odd.
  function automatic logic odd_parity(input logic [DATA_BITS-1:0] d);
    return ~(^d);
  endfunction

endpackage

// File: rtl/odd_parity_serial_tx_if.sv
// Valid/ready word handshake into the serial transmitter.
`timescale 1ns/1ps
interface odd_parity_serial_tx_if;
  import odd_parity_pkg::*;

  logic [DATA_BITS-1:0] data_in;
  logic                 data_valid;
  logic                 data_ready;

  modport master (output data_in, output data_valid, input data_ready);
  modport slave  (input data_in, input data_valid, output data_ready);

endinterface

// File: rtl/odd_parity_serial_tx_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the wrap cycle.
`timescale 1ns/1ps
module odd_parity_bit_timer #(
  parameter int CLKS_PER_BIT = 4,
  parameter int CNT_W        = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic bit_tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  assign bit_tick = (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (clear || bit_tick)
      cnt <= '0;
    else
      cnt <= cnt + CNT_W'(1);
  end

endmodule

// File: rtl/odd_parity_serial_tx.sv
// Framed serial transmitter: start, 3 data bits LSB-first, odd parity, stop.
`timescale 1ns/1ps
module odd_parity_serial_tx
  import odd_parity_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int CNT_W        = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  odd_parity_serial_tx_if.slave  bus,
  output logic                   tx,
  output logic                   busy,
  output logic                   frame_done
);

  localparam logic [1:0] LAST_IDX = 2'(DATA_BITS - 1);

  logic [2:0]           state;
  logic [2:0]           state_next;
  logic [DATA_BITS-1:0] shift;
  logic                 parity;
  logic [1:0]           idx;
  logic [1:0]           idx_inc;
  logic                 hs;
  logic                 bit_tick;
  logic                 tx_d;
  logic                 busy_d;
  logic                 done_d;

  assign bus.data_ready = (state == ST_IDLE);
  assign hs             = bus.data_valid && bus.data_ready;
  assign idx_inc        = idx + 2'd1;

  odd_parity_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .CNT_W        (CNT_W)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (hs),
    .bit_tick (bit_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= ST_IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (hs)                          state_next = ST_START;
      ST_START:  if (bit_tick)                    state_next = ST_DATA;
      ST_DATA:   if (bit_tick && idx == LAST_IDX) state_next = ST_PARITY;
      ST_PARITY: if (bit_tick)                    state_next = ST_STOP;
      ST_STOP:   if (bit_tick)                    state_next = ST_IDLE;
      default:                                    state_next = ST_IDLE;
    endcase
  end

  // Next line value is computed one bit ahead so tx can be a plain register.
  always_comb begin
    tx_d   = tx;
    busy_d = (state_next != ST_IDLE);
    done_d = (state == ST_STOP) && bit_tick;
    case (state)
      ST_IDLE:   if (hs) tx_d = 1'b0;
      ST_START:  if (bit_tick) tx_d = shift[0];
      ST_DATA:   if (bit_tick) tx_d = (idx == LAST_IDX) ? parity : shift[idx_inc];
      ST_PARITY: if (bit_tick) tx_d = 1'b1;
      ST_STOP:   if (bit_tick) tx_d = 1'b1;
      default:   tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx         <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      shift      <= '0;
      parity     <= 1'b0;
      idx        <= '0;
    end else begin
      tx         <= tx_d;
      busy       <= busy_d;
      frame_done <= done_d;
      if (hs) begin
        shift  <= bus.data_in;
        parity <= odd_parity(bus.data_in);
      end
      if (state == ST_DATA && bit_tick)
        idx <= (idx == LAST_IDX) ? 2'd0 : idx_inc;
    end
  end

endmodule

// File: tb/tb_odd_parity_serial_tx.sv
// Directed and randomized bench for odd_parity_serial_tx at 4 and 1 clocks per bit.
`timescale 1ns/1ps
module tb_odd_parity_serial_tx;
  import odd_parity_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  odd_parity_serial_tx_if hs4 ();
  odd_parity_serial_tx_if hs1 ();

  logic tx4, busy4, done4;
  logic tx1, busy1, done1;

  odd_parity_serial_tx #(.CLKS_PER_BIT(4), .CNT_W(8)) dut4 (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (hs4.slave),
    .tx         (tx4),
    .busy       (busy4),
    .frame_done (done4)
  );

  odd_parity_serial_tx #(.CLKS_PER_BIT(1), .CNT_W(8)) dut1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (hs1.slave),
    .tx         (tx1),
    .busy       (busy1),
    .frame_done (done1)
  );

  int     checks = 0;
  int     failures = 0;
  longint t_hs = 0;

  function automatic logic obs_tx(input int sel);
    return (sel != 0) ? tx1 : tx4;
  endfunction
  function automatic logic obs_busy(input int sel);
    return (sel != 0) ? busy1 : busy4;
  endfunction
  function automatic logic obs_done(input int sel);
    return (sel != 0) ? done1 : done4;
  endfunction
  function automatic logic obs_ready(input int sel);
    return (sel != 0) ? hs1.data_ready : hs4.data_ready;
  endfunction

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input int sel, input logic v, input logic [2:0] d);
    if (sel != 0) begin
      hs1.data_valid = v;
      hs1.data_in    = d;
    end else begin
      hs4.data_valid = v;
      hs4.data_in    = d;
    end
  endtask

  // Called at a falling edge with the DUT idle; returns at the falling edge
  // of the first idle cycle after the frame (the frame_done cycle).
  task automatic do_frame(input int sel, input logic [2:0] d, input bit chain,
                          input logic [2:0] nd);
    logic exp_bits [FRAME_BITS];
    int   n;
    n = (sel != 0) ? 1 : 4;
    exp_bits[0] = 1'b0;
    for (int i = 0; i < DATA_BITS; i++) exp_bits[1+i] = d[i];
    exp_bits[4] = (($countones(d) % 2) == 0);
    exp_bits[5] = 1'b1;

    check($sformatf("ready_pre s%0d d%0d", sel, d), obs_ready(sel), 1'b1);
    drive(sel, 1'b1, d);
    @(posedge clk);
    t_hs = $time;
    for (int c = 0; c < FRAME_BITS * n; c++) begin
      @(negedge clk);
      if (chain)
        drive(sel, 1'b1, (c == FRAME_BITS * n - 1) ? nd : 3'($urandom));
      else
        drive(sel, 1'($urandom_range(0, 1)), 3'($urandom));
      check($sformatf("tx s%0d d%0d c%0d", sel, d, c), obs_tx(sel), exp_bits[c / n]);
      check($sformatf("busy s%0d c%0d", sel, c), obs_busy(sel), 1'b1);
      check($sformatf("done_low s%0d c%0d", sel, c), obs_done(sel), 1'b0);
      check($sformatf("ready_low s%0d c%0d", sel, c), obs_ready(sel), 1'b0);
    end
    @(negedge clk);
    check($sformatf("done_pulse s%0d d%0d", sel, d), obs_done(sel), 1'b1);
    check($sformatf("busy_end s%0d", sel), obs_busy(sel), 1'b0);
    check($sformatf("ready_end s%0d", sel), obs_ready(sel), 1'b1);
    check($sformatf("tx_idle s%0d", sel), obs_tx(sel), 1'b1);
    if (!chain) drive(sel, 1'b0, d);
  endtask

  initial begin
    longint t1;
    longint t2;

    // Reset held with valid asserted on both instances: nothing may start.
    rst_n = 1'b0;
    drive(0, 1'b1, 3'b101);
    drive(1, 1'b1, 3'b011);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("rst tx4 c%0d", c), tx4, 1'b1);
      check($sformatf("rst ready4 c%0d", c), hs4.data_ready, 1'b1);
      check($sformatf("rst busy4 c%0d", c), busy4, 1'b0);
      check($sformatf("rst done4 c%0d", c), done4, 1'b0);
      check($sformatf("rst tx1 c%0d", c), tx1, 1'b1);
      check($sformatf("rst busy1 c%0d", c), busy1, 1'b0);
    end
    rst_n = 1'b1;
    drive(1, 1'b0, 3'b000);

    // First handshake lands on the first edge after release.
    do_frame(0, 3'b000, 1'b0, 3'b000);
    do_frame(0, 3'b111, 1'b0, 3'b000);
    do_frame(0, 3'b101, 1'b0, 3'b000);

    // Back-to-back with valid held high.
    do_frame(0, 3'b011, 1'b1, 3'b100);
    t1 = t_hs;
    do_frame(0, 3'b100, 1'b0, 3'b000);
    t2 = t_hs;
    check_int("b2b_period_cycles", (t2 - t1) / 10, 25);

    // Abort in DATA bit 1.
    drive(0, 1'b1, 3'b010);
    @(posedge clk);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c == 0) drive(0, 1'b0, 3'b010);
    end
    rst_n = 1'b0;
    #1;
    check("abort tx", tx4, 1'b1);
    check("abort busy", busy4, 1'b0);
    check("abort ready", hs4.data_ready, 1'b1);
    check("abort done", done4, 1'b0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check($sformatf("abort hold done c%0d", c), done4, 1'b0);
      check($sformatf("abort hold tx c%0d", c), tx4, 1'b1);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("post_abort done", done4, 1'b0);
    do_frame(0, 3'b110, 1'b0, 3'b000);

    // One clock per bit.
    do_frame(1, 3'b001, 1'b0, 3'b000);

    for (int i = 0; i < 6; i++) do_frame(0, 3'($urandom), 1'b0, 3'b000);
    for (int i = 0; i < 8; i++) do_frame(1, 3'($urandom), 1'b0, 3'b000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/odd_parity_serial_tx.md
Name: odd_parity_serial_tx

Overview:
Serial transmitter that sits directly downstream of the 3-bit odd-parity generator path.
- Accepts one 3-bit word per valid/ready handshake and computes its odd-parity bit internally.
- Serialises each word as one framed bitstream: start, 3 data bits LSB-first, parity, stop.
- Each bit is held for a programmable number of clocks; the line feeds the board-level serial link.

Parameters:
CLKS_PER_BIT, 4, clock cycles each serial bit is held on tx; legal range 1..255.
CNT_W, 8, width of the bit-timer counter; must satisfy 2**CNT_W > CLKS_PER_BIT.

Ports:
clk         input   1  system clock, rising-edge active
rst_n       input   1  asynchronous active-low reset
data_in     input   3  word to transmit; sampled only on handshake
data_valid  input   1  data_in is valid this cycle
data_ready  output  1  block can accept a word this cycle
tx          output  1  serial line, idle high
busy        output  1  frame in progress (any state except IDLE)
frame_done  output  1  one-cycle pulse after the stop bit completes

Behaviour:
Clock and reset:
- Single clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: tx=1, data_ready=1, busy=0, frame_done=0, state=IDLE, bit timer=0, bit index=0, shift register=0.

Outputs and handshake:
- All outputs are registered except data_ready, which is decoded as (state==IDLE).
- A handshake occurs on a rising edge where data_valid && data_ready.
- On that edge: capture data_in into the shift register, capture the parity bit, and move to START with tx<=0.

Parity:
- parity = 1 when data_in has an even number of ones (codes 0,3,5,6); parity = 0 for codes 1,2,4,7.
- Transmitted data plus parity therefore always contains an odd number of ones.

States:
- IDLE: tx=1. Wait for the handshake.
- START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- DATA: tx=shift[idx] for CLKS_PER_BIT cycles per bit. After idx 2, go to PARITY.
- PARITY: tx=parity for CLKS_PER_BIT cycles, then go to STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles, then go to IDLE. frame_done<=1 on the same edge for exactly one cycle.

Timing:
- Bit timer counts 0..CLKS_PER_BIT-1 and wraps to 0 on each bit boundary. State and tx change only on the wrap.
- One frame is 6*CLKS_PER_BIT cycles of line activity, measured from the handshake edge.
- Minimum handshake-to-handshake period is 6*CLKS_PER_BIT+1 cycles, because the block always spends at least one IDLE cycle between frames.
- With data_valid held high, the next word is accepted in the first IDLE cycle, coincident with frame_done=1.

Boundary conditions:
- data_in or data_valid changes while busy are ignored; no queueing.
- CLKS_PER_BIT=1: every bit lasts exactly one cycle and the timer is constantly at wrap.
- Reset mid-frame: tx goes high immediately (asynchronously) and all state clears. The aborted frame is lost, and no frame_done is generated.
- data_valid asserted during reset: no capture. The first handshake happens on the first edge after rst_n deasserts.

Decomposition:
Shared package odd_parity_pkg holds:
- state encoding constants ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP (3-bit);
- constant DATA_BITS=3 and FRAME_BITS=6;
- the odd-parity function (3-bit in, 1-bit out).

One sub-module is natural: odd_parity_bit_timer.
- Parameterised by CLKS_PER_BIT and CNT_W.
- Inputs: clk, rst_n, and a clear (driven on handshake).
- Output: a one-cycle bit_tick on wrap.
- The FSM and shift/index logic stay in the top module.

Test Plan:
1. Reset, with rst_n low for 3 cycles and data_valid=1 -> tx=1, data_ready=1, busy=0, frame_done=0 throughout; no frame starts until after rst_n rises.
2. CLKS_PER_BIT=4, send 3'b000 -> tx is 0,0,0,0,1,1, each value held 4 cycles (24 cycles); busy high for 24 cycles; frame_done pulses on cycle 24 after the handshake.
3. CLKS_PER_BIT=4, send 3'b111 -> tx is 0,1,1,1,0,1 (parity 0). Also send 3'b101 -> tx is 0,1,0,1,1,1 (parity 1).
4. Back-to-back: data_valid held high with 3'b011, then 3'b100 -> second START falling edge of tx occurs exactly 25 cycles after the first. data_in toggled mid-frame does not alter the transmitted bits.
5. Reset asserted in DATA bit 1 of a frame -> tx=1 within the same cycle, busy=0, no frame_done. A following send of 3'b110 produces 0,0,1,1,1,1.
6. CLKS_PER_BIT=1, send 3'b001 -> tx is 0,1,0,0,0,1 over 6 consecutive cycles; data_ready returns high on cycle 6.
